vga_scan_out: RTL



---
 rtl/vga_scan_out.sv | 113 +++++++++++
 1 files changed

// File: rtl/vga_scan_out.sv
// vga_scan_out: 640x480@60 scan timing, renderer-latency sync delay and registered VGA pin stage.
// Optional VGA_TEST_PATTERN_EN adds test_en and an 8-bar colour test pattern.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int PIPE_DLY = 1
) (
  input  logic        vga_clk,
  input  logic        vga_rst_n,
  input  logic [11:0] pixel_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hs,
  output logic        vs,
  output logic        frame_start
);
  localparam logic [9:0] HA   = 10'(H_ACTIVE);
  localparam logic [9:0] HS_B = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] HT_M = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VA   = 10'(V_ACTIVE);
  localparam logic [9:0] VS_B = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] VT_M = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic       SP   = 1'(SYNC_POL);

  logic [9:0]  r_h, r_v, w_h_nxt, w_v_nxt;
  logic        w_h_act, w_v_act, w_de, w_hs, w_vs;
  logic        r_de_d [PIPE_DLY];
  logic        r_hs_d [PIPE_DLY];
  logic        r_vs_d [PIPE_DLY];
  logic [11:0] r_rgb, w_src;
  logic        r_hs, r_vs, r_fs;

  assign w_h_nxt = (r_h == HT_M) ? '0 : r_h + 10'd1;
  assign w_v_nxt = (r_h != HT_M) ? r_v : (r_v == VT_M) ? '0 : r_v + 10'd1;
  assign w_h_act = r_h < HA;
  assign w_v_act = r_v < VA;
  assign w_de    = w_h_act && w_v_act;
  assign w_hs    = (r_h >= HS_B) && (r_h <= HS_E);
  assign w_vs    = (r_v >= VS_B) && (r_v <= VS_E);
  assign x_pos   = w_h_act ? r_h : '0;
  assign y_pos   = w_v_act ? r_v : '0;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [11:0] BARS [8] = '{12'hFFF, 12'h0FF, 12'hFF0, 12'h0F0,
                                       12'hF0F, 12'h00F, 12'hF00, 12'h000};
  logic [9:0] r_x_d [PIPE_DLY];
  logic [2:0] w_bar;
  // x travels with de so the bar index lines up with the delayed blanking
  always_ff @(posedge vga_clk or negedge vga_rst_n)
    if (!vga_rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) r_x_d[i] <= '0;
    end else begin
      r_x_d[0] <= x_pos;
      for (int i = 1; i < PIPE_DLY; i++) r_x_d[i] <= r_x_d[i-1];
    end
  assign w_bar = 3'(r_x_d[PIPE_DLY-1] / 10'd80);
  assign w_src = test_en ? BARS[w_bar] : pixel_data;
`else
  assign w_src = pixel_data;
`endif

  always_ff @(posedge vga_clk or negedge vga_rst_n)
    if (!vga_rst_n) begin
      r_h   <= '0;
      r_v   <= '0;
      r_fs  <= 1'b0;
      r_rgb <= '0;
      r_hs  <= ~SP;
      r_vs  <= ~SP;
      for (int i = 0; i < PIPE_DLY; i++) begin
        r_de_d[i] <= 1'b0;
        r_hs_d[i] <= 1'b0;
        r_vs_d[i] <= 1'b0;
      end
    end else begin
      r_h       <= w_h_nxt;
      r_v       <= w_v_nxt;
      r_fs      <= (w_h_nxt == '0) && (w_v_nxt == '0);
      r_de_d[0] <= w_de;
      r_hs_d[0] <= w_hs;
      r_vs_d[0] <= w_vs;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_de_d[i] <= r_de_d[i-1];
        r_hs_d[i] <= r_hs_d[i-1];
        r_vs_d[i] <= r_vs_d[i-1];
      end
      r_rgb <= r_de_d[PIPE_DLY-1] ? w_src : '0;
      r_hs  <= r_hs_d[PIPE_DLY-1] ? SP : ~SP;
      r_vs  <= r_vs_d[PIPE_DLY-1] ? SP : ~SP;
    end

  assign vga_b       = r_rgb[11:8];
  assign vga_g       = r_rgb[7:4];
  assign vga_r       = r_rgb[3:0];
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign frame_start = r_fs;
endmodule
